hart_puls_gen: RTL

- Heartbeat transmitter: produces a `hartin`-style pulse train at a programmable beats-per-minute rate.
- Drives the heart-rhythm receiver input for bench demos and self-test, standing in for the real heart sensor.
- The rate slews gradually toward a target, so the receiver sees realistic stress rises and falls.
- Sits beside the clock-delay block and is muxed onto the heart input line at top level.

---
 rtl/hart_puls_gen_pkg.sv | 30 +++
 rtl/hart_puls_gen_ms_tick_gen.sv | 30 +++
 rtl/hart_puls_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/hart_puls_gen_pkg.sv
// Shared constants, state codes and rate helpers for the heartbeat pulse generator.
package hart_puls_gen_pkg;

    localparam int MS_PER_MIN = 60000;
    localparam int ACC_W      = 17;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t RUN_LOW  = 2'd1;
    localparam state_t RUN_HIGH = 2'd2;

    function automatic logic [7:0] clamp_bpm(input logic [7:0] v,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    // Move cur toward tgt by at most step.
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt,
                                               input logic [7:0] step);
        if (tgt > cur)      return ((tgt - cur) > step) ? cur + step : tgt;
        else if (tgt < cur) return ((cur - tgt) > step) ? cur - step : tgt;
        else                return cur;
    endfunction

endpackage

// File: rtl/hart_puls_gen_ms_tick_gen.sv
// Millisecond tick divider: one-cycle tick every TICK_DIV clocks while run is high.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) cnt_d = '0;
        else              cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hart_puls_gen.sv
// Heartbeat transmitter: phase-accumulator beat timing with a slewed bpm rate.
module hart_puls_gen
    import hart_puls_gen_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int PULSE_MS  = 100,
    parameter int BPM_MIN   = 30,
    parameter int BPM_MAX   = 220,
    parameter int RAMP_STEP = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] bpm_target,
    output logic       hartout,
    output logic       beat,
    output logic [7:0] bpm_cur
);

    localparam int WW = (PULSE_MS > 1) ? $clog2(PULSE_MS) : 1;
    localparam logic [ACC_W-1:0] FULL     = ACC_W'(MS_PER_MIN);
    localparam logic [WW-1:0]    WID_LOAD = WW'(PULSE_MS - 1);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WW-1:0]     wid_q, wid_d;
    logic              hart_q, hart_d;
    logic              beat_q, beat_d;
    logic [7:0]        bpm_q, bpm_d;

    logic              run;
    logic              tick;
    logic              fire;
    logic [7:0]        tgt_c;
    logic [ACC_W-1:0]  sum;

    assign tgt_c = clamp_bpm(bpm_target, 8'(BPM_MIN), 8'(BPM_MAX));
    assign run   = (state_q != IDLE) && enable;
    assign sum   = acc_q + ACC_W'(bpm_q);
    assign fire  = tick && (sum >= FULL);

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        wid_d   = wid_q;
        hart_d  = hart_q;
        beat_d  = 1'b0;
        bpm_d   = bpm_q;
        case (state_q)
            IDLE: begin
                hart_d = 1'b0;
                bpm_d  = tgt_c;
                acc_d  = '0;
                wid_d  = '0;
                if (enable) state_d = RUN_LOW;
            end
            RUN_LOW, RUN_HIGH: begin
                if (!enable) begin
                    state_d = IDLE;
                    hart_d  = 1'b0;
                    acc_d   = '0;
                    wid_d   = '0;
                end else begin
                    if (tick) acc_d = fire ? (sum - FULL) : sum;
                    // A beat outranks width expiry on the same tick, retriggering the pulse.
                    if (fire) begin
                        state_d = RUN_HIGH;
                        hart_d  = 1'b1;
                        beat_d  = 1'b1;
                        wid_d   = WID_LOAD;
                        bpm_d   = ramp_toward(bpm_q, tgt_c, 8'(RAMP_STEP));
                    end else if (state_q == RUN_HIGH && tick) begin
                        if (wid_q == '0) begin
                            state_d = RUN_LOW;
                            hart_d  = 1'b0;
                        end else begin
                            wid_d = wid_q - 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hart_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            wid_q   <= '0;
            hart_q  <= 1'b0;
            beat_q  <= 1'b0;
            bpm_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wid_q   <= wid_d;
            hart_q  <= hart_d;
            beat_q  <= beat_d;
            bpm_q   <= bpm_d;
        end
    end

    assign hartout = hart_q;
    assign beat    = beat_q;
    assign bpm_cur = bpm_q;

endmodule
